sv_dot_accumulator: RTL and testbench

//  Receiving end of the memory-control pixel stream. Consumes one SV1/SV2/test pixel triple
//  per accepted cycle and forms two unsigned dot products (x_test . SV1, x_test . SV2) over
//  NUM_OF_PIXELS pixels. Emits one result pair per support vector, NUM_OF_SV pairs per run.

---
 rtl/sv_dot_accumulator.sv | 141 ++++++++++++++
 tb/tb_sv_dot_accumulator.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sv_dot_accumulator.sv
// rtl/sv_dot_accumulator.sv - dual unsigned dot-product accumulator for the SVM pixel stream
//
// Purpose: one (sv_load1, sv_load2, x_test) pixel triple is taken on each accepted cycle.
// The block accumulates x_test*sv_load1 and x_test*sv_load2 over NUM_OF_PIXELS pixels, then
// publishes the pair with its support-vector index. There are NUM_OF_SV pairs per run.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   en                   run enable: starts a run from IDLE, and DONE returns to IDLE when en=0
//   re, stall_MEM        a pixel is accepted only in RUN with re=1 and stall_MEM=0
//   sv_load1/2, x_test   pixel inputs, XLEN_PIXEL bits, unsigned
//   dot1, dot2           last completed dot products, ACC_W bits, held between pulses
//   dot_valid            one-cycle pulse when dot1/dot2/sv_idx update
//   sv_idx               support-vector index of dot1/dot2
//   busy, done           state == RUN, state == DONE
module sv_dot_accumulator #(
    parameter int XLEN_PIXEL    = 8,
    parameter int NUM_OF_PIXELS = 4,
    parameter int NUM_OF_SV     = 10,
    localparam int ACC_W        = 2 * XLEN_PIXEL + $clog2(NUM_OF_PIXELS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  re,
    input  logic                  stall_MEM,
    input  logic [XLEN_PIXEL-1:0] sv_load1,
    input  logic [XLEN_PIXEL-1:0] sv_load2,
    input  logic [XLEN_PIXEL-1:0] x_test,
    output logic [ACC_W-1:0]      dot1,
    output logic [ACC_W-1:0]      dot2,
    output logic                  dot_valid,
    output logic [7:0]            sv_idx,
    output logic                  busy,
    output logic                  done
);

    localparam int PIX_W  = $clog2(NUM_OF_PIXELS);
    localparam int PROD_W = 2 * XLEN_PIXEL;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [PIX_W-1:0]   pix_cnt_q;
    logic [7:0]         sv_cnt_q;
    logic [ACC_W-1:0]   acc1_q;
    logic [ACC_W-1:0]   acc2_q;
    logic [ACC_W-1:0]   dot1_q;
    logic [ACC_W-1:0]   dot2_q;
    logic [7:0]         sv_idx_q;
    logic               dot_valid_q;

    logic               fire;
    logic               last_pix;
    logic               last_sv;
    logic [PROD_W-1:0]  prod1;
    logic [PROD_W-1:0]  prod2;
    logic [ACC_W-1:0]   sum1_d;
    logic [ACC_W-1:0]   sum2_d;

    assign fire     = (state_q == ST_RUN) && re && !stall_MEM;
    assign last_pix = (pix_cnt_q == PIX_W'(NUM_OF_PIXELS - 1));
    assign last_sv  = (sv_cnt_q == 8'(NUM_OF_SV - 1));

    // Full-width products are zero-extended, so the sum cannot wrap at ACC_W.
    always_comb begin
        prod1  = PROD_W'(x_test) * PROD_W'(sv_load1);
        prod2  = PROD_W'(x_test) * PROD_W'(sv_load2);
        sum1_d = acc1_q + ACC_W'(prod1);
        sum2_d = acc2_q + ACC_W'(prod2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pix_cnt_q   <= '0;
            sv_cnt_q    <= '0;
            acc1_q      <= '0;
            acc2_q      <= '0;
            dot1_q      <= '0;
            dot2_q      <= '0;
            sv_idx_q    <= '0;
            dot_valid_q <= 1'b0;
        end else begin
            dot_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (en) begin
                        state_q   <= ST_RUN;
                        pix_cnt_q <= '0;
                        sv_cnt_q  <= '0;
                        acc1_q    <= '0;
                        acc2_q    <= '0;
                    end
                end
                ST_RUN: begin
                    if (fire) begin
                        if (last_pix) begin
                            // Publish the finished SV. The accumulators restart at zero, so
                            // the next SV may begin on the following cycle with no gap.
                            dot1_q      <= sum1_d;
                            dot2_q      <= sum2_d;
                            sv_idx_q    <= sv_cnt_q;
                            dot_valid_q <= 1'b1;
                            acc1_q      <= '0;
                            acc2_q      <= '0;
                            pix_cnt_q   <= '0;
                            if (last_sv) begin
                                state_q <= ST_DONE;
                            end else begin
                                sv_cnt_q <= sv_cnt_q + 8'd1;
                            end
                        end else begin
                            acc1_q    <= sum1_d;
                            acc2_q    <= sum2_d;
                            pix_cnt_q <= pix_cnt_q + PIX_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (!en) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dot1      = dot1_q;
    assign dot2      = dot2_q;
    assign sv_idx    = sv_idx_q;
    assign dot_valid = dot_valid_q;
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_sv_dot_accumulator.sv
// tb/tb_sv_dot_accumulator.sv - scoreboard bench for sv_dot_accumulator
module tb_sv_dot_accumulator;

    localparam int XL  = 8;
    localparam int NP  = 4;
    localparam int NSV = 10;
    localparam int AW  = 2 * XL + $clog2(NP);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          re = 1'b0;
    logic          stall_MEM = 1'b0;
    logic [XL-1:0] sv_load1 = '0;
    logic [XL-1:0] sv_load2 = '0;
    logic [XL-1:0] x_test = '0;
    logic [AW-1:0] dot1;
    logic [AW-1:0] dot2;
    logic          dot_valid;
    logic [7:0]    sv_idx;
    logic          busy;
    logic          done;

    sv_dot_accumulator #(.XLEN_PIXEL(XL), .NUM_OF_PIXELS(NP), .NUM_OF_SV(NSV)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .re(re), .stall_MEM(stall_MEM),
        .sv_load1(sv_load1), .sv_load2(sv_load2), .x_test(x_test),
        .dot1(dot1), .dot2(dot2), .dot_valid(dot_valid), .sv_idx(sv_idx),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned d1;
        int unsigned d2;
        int unsigned idx;
        int          at;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_fail = 0;

    // Reference model: 0 idle, 1 running, 2 finished.
    int          mst = 0;
    int          m_pix = 0;
    int          m_sv = 0;
    int unsigned m_s1 = 0;
    int unsigned m_s2 = 0;
    int unsigned last1 = 0;
    int unsigned last2 = 0;
    int unsigned lastidx = 0;

    task automatic chk(input string name, input longint act, input longint expv);
        n_cmp++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: checks every cycle away from the active edge.
    always @(negedge clk) begin
        if (dot_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_dot_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pulse_cycle", cyc, e.at);
                chk("dot1", dot1, e.d1);
                chk("dot2", dot2, e.d2);
                chk("sv_idx", sv_idx, e.idx);
                last1 = e.d1;
                last2 = e.d2;
                lastidx = e.idx;
            end
        end else begin
            if (sb.size() != 0 && sb[0].at <= cyc) begin
                chk("missing_dot_valid", 0, 1);
                void'(sb.pop_front());
            end
            chk("dot1_hold", dot1, last1);
            chk("dot2_hold", dot2, last2);
            chk("sv_idx_hold", sv_idx, lastidx);
        end
        chk("busy", busy, mst == 1);
        chk("done", done, mst == 2);
    end

    // One clock of stimulus; the model decides from pre-edge state and commits after the edge.
    task automatic step(input logic e, input logic r, input logic s,
                        input int x, input int a, input int b);
        bit fire;
        en = e; re = r; stall_MEM = s;
        x_test = XL'(x); sv_load1 = XL'(a); sv_load2 = XL'(b);
        fire = (mst == 1) && r && !s;
        @(posedge clk);
        #1;
        if (fire) begin
            m_s1 += x * a;
            m_s2 += x * b;
            if (m_pix == NP - 1) begin
                sb.push_back('{m_s1, m_s2, m_sv, cyc});
                m_s1 = 0; m_s2 = 0; m_pix = 0;
                if (m_sv == NSV - 1) mst = 2;
                else m_sv++;
            end else begin
                m_pix++;
            end
        end else if (mst == 0 && e) begin
            mst = 1; m_pix = 0; m_sv = 0; m_s1 = 0; m_s2 = 0;
        end else if (mst == 2 && !e) begin
            mst = 0;
        end
    endtask

    task automatic rnd_step(input logic e, input logic r, input logic s);
        step(e, r, s, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    endtask

    task automatic finish_run_random(input bit stalls);
        int guard;
        guard = 0;
        while (mst == 1 && guard < 2000) begin
            if (stalls) rnd_step(1'b1, ($urandom % 4) != 0, ($urandom % 4) == 0);
            else        rnd_step(1'b1, 1'b1, 1'b0);
            guard++;
        end
        chk("run_reached_done", mst, 2);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_dot1", dot1, 0);
        chk("reset_dot2", dot2, 0);
        chk("reset_valid", dot_valid, 0);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0, 0);

        // Start a run; SV0 uses the basic vectors (expect 120 / 92).
        step(1, 1, 0, 0, 0, 0);
        step(0, 1, 0, 10, 1, 2);
        step(0, 1, 0, 11, 2, 2);
        step(0, 1, 0, 12, 3, 2);
        step(0, 1, 0, 13, 4, 2);
        chk("basic_model_dot1", sb.size() > 0 ? sb[0].d1 : 0, 120);

        // SV1: same data with a 3-cycle stall and one re=0 bubble carrying junk.
        step(1, 1, 0, 10, 1, 2);
        step(1, 1, 0, 11, 2, 2);
        repeat (3) rnd_step(1, 1, 1);
        rnd_step(1, 0, 0);
        step(1, 1, 0, 12, 3, 2);
        step(1, 1, 0, 13, 4, 2);

        // SV2: all-ones maximum, 260100 with no wrap.
        repeat (NP) step(1, 1, 0, 255, 255, 255);

        // Remaining SVs with random bubbles, then done must hold while en stays high.
        finish_run_random(1'b1);
        repeat (3) step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Idle gating: data and re active but en low.
        repeat (20) rnd_step(0, 1, 0);

        // Reset after two pixels of SV3.
        step(1, 1, 0, 0, 0, 0);
        repeat (3 * NP + 2) rnd_step(1, 1, 0);
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_dot1", dot1, 0);
        chk("midrun_reset_dot2", dot2, 0);
        chk("midrun_reset_idx", sv_idx, 0);
        chk("midrun_reset_busy", busy, 0);
        mst = 0; m_pix = 0; m_sv = 0; m_s1 = 0; m_s2 = 0;
        sb.delete();
        last1 = 0; last2 = 0; lastidx = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fresh run, back-to-back pixels, no carry-over.
        step(1, 1, 0, 0, 0, 0);
        finish_run_random(1'b0);
        step(0, 0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
